bp_axi4_mem_arbiter: RTL and testbench
======================================

Name: bp_axi4_mem_arbiter

Overview:
- Shares the single DRAM AXI4 manager port (m01_axi_*) between two AXI4 requesters, e.g. the BP memory-side bridge and a host DMA/loader.
- Read and write channels are arbitrated independently, each with round-robin fairness and one outstanding transaction per channel.
- Responses are routed back by the stored grant, and IDs pass through unchanged.
- Sits between bp_axi4_top's memory output and the DRAM controller.

Parameters:
ADDR_WIDTH, 64, AXI address width on all ports
DATA_WIDTH, 128, AXI data width on all ports
ID_WIDTH, 4, AXI ID width on all ports

Ports:
m01_axi_aclk  in  1  sole clock
m01_axi_aresetn  in  1  reset; synchronous, active-low
sN_axi_awaddr/awid/awlen/awsize/awburst, awvalid  in  ADDR/ID/8/3/2, 1  requester N (N=0,1) write address
sN_axi_awready  out  1  write address accept
sN_axi_wdata/wstrb/wlast/wvalid  in  DATA/DATA/8/1/1  write data
sN_axi_wready  out  1  write data accept
sN_axi_bvalid/bid/bresp  out  1/ID/2  write response
sN_axi_bready  in  1
sN_axi_araddr/arid/arlen/arsize/arburst, arvalid  in  as AW  read address
sN_axi_arready  out  1
sN_axi_rdata/rid/rresp/rlast/rvalid  out  DATA/ID/2/1/1  read data
sN_axi_rready  in  1
m01_axi_aw*, w*, b*, ar*, r*  mirror of sN_* with directions reversed  shared DRAM port
m01_axi_awlock/arlock, awcache/arcache, awprot/arprot, awqos/arqos, awregion/arregion  out  1,4,3,4,4  constants: 0, 4'b0011, 0, 0, 0

Behaviour:
- Reset (aresetn low at clock edge):
  - write FSM -> W_IDLE; read FSM -> R_IDLE.
  - wr_last and rd_last set to 1, so requester 0 wins the first tie.
  - All valid/ready outputs 0. Other outputs are don't-care while the matching valid is 0.
  - Reset mid-transaction abandons it; no completion is issued.
- Write FSM:
  - W_IDLE: when any sN_awvalid=1, register wr_gnt:
    - both valid: wr_gnt = ~wr_last;
    - one valid: that requester.
    - Go to W_ADDR. No AW is forwarded in the grant cycle; this adds one cycle of latency.
  - W_ADDR: m01_awvalid = s[gnt]_awvalid; AW fields are muxed combinationally from the granted requester. s[gnt]_awready = m01_awready; the other awready = 0. On AW handshake go to W_DATA and load beat_cnt = awlen.
  - W_DATA: W passes combinationally between the granted requester and m01; the other wready = 0. On each beat handshake, beat_cnt decrements. Handshake with wlast=1 -> W_RESP.
  - W_RESP: m01_bready = s[gnt]_bready; B is forwarded to the granted requester only. On B handshake: wr_last <= wr_gnt, go to W_IDLE.
  - Non-granted bvalid is always 0.
- Read FSM (R_IDLE, R_ADDR, R_DATA):
  - Same grant rule using rd_last.
  - On AR handshake go to R_DATA. R beats are forwarded to s[gnt].
  - On an R handshake with rlast=1: rd_last <= rd_gnt, go to R_IDLE.
- Read and write FSMs are fully independent. Concurrent read from one requester and write from the other (or the same one) is allowed.
- Grant is held until completion even if the other requester is waiting. There is no preemption.
- The AXI protocol forbids a requester dropping awvalid/arvalid before handshake; the arbiter holds the grant regardless.
- protocol_err (internal, sticky until reset): set when wlast=1 arrives with beat_cnt != 0, or wlast=0 arrives with beat_cnt == 0. Data still passes through. Simulation asserts on protocol_err.
- The arbiter is throughput-neutral within a burst: zero added latency per beat. Added latency is 1 cycle per address phase.

Test Plan:
- Reset, then s0 writes awaddr=0x1000, awlen=3, 4 beats -> m01 AW appears 1 cycle after awvalid; 4 W beats pass unchanged; s0 sees bvalid with bid equal to its awid; s1 never sees bvalid or awready.
- s0 and s1 both assert arvalid in the same cycle after reset -> s0 granted first; s1 granted on the cycle after s0's rlast handshake; next tie -> s0 wins again (alternation over 4 rounds: s0, s1, s0, s1).
- s0 read (arlen=7) overlapping an s1 write (awlen=0) -> both proceed concurrently; rdata/rid go only to s0, bresp only to s1.
- m01_wready/rready toggled randomly, with backpressure on sN_bready/rready -> no beat lost or duplicated; data order preserved; scoreboard matches.
- Assert aresetn low in W_DATA after 2 of 4 beats -> next cycle all readies/valids are 0 and the FSM is in W_IDLE; a new s1 write then completes normally with s0 given priority on a tie.
- s1 sends wlast on beat 2 of awlen=3 -> protocol_err asserted; response still forwarded.

Source files
------------

// File: rtl/bp_axi4_mem_arbiter.sv
// bp_axi4_mem_arbiter
// Shares the single DRAM AXI4 manager port (m01_axi_*) between two AXI4
// requesters (s0_axi_*, s1_axi_*). Read and write channels are arbitrated
// independently. Each channel uses round-robin fairness and allows one
// outstanding transaction.
//
// Ports:
//   m01_axi_aclk / m01_axi_aresetn : clock, synchronous active-low reset
//   s0_axi_*, s1_axi_*              : requester-side AXI4 subordinate ports
//   m01_axi_*                       : shared DRAM-side AXI4 manager port
//   dbg_wr_state / dbg_rd_state     : current write / read FSM state
//   dbg_protocol_err                : sticky W-burst length violation flag
//
// Handshake semantics: a beat transfers on a rising edge where valid and ready
// are both 1. Valid never depends combinationally on ready from the same side.
// The arbiter forwards valid from the granted side, and it returns ready to the
// granted side only. Every other valid/ready output is held at 0.
module bp_axi4_mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    m01_axi_aclk,
    input  logic                    m01_axi_aresetn,
    // requester 0
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s0_axi_awid,
    input  logic [7:0]              s0_axi_awlen,
    input  logic [2:0]              s0_axi_awsize,
    input  logic [1:0]              s0_axi_awburst,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wlast,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic                    s0_axi_bvalid,
    output logic [ID_WIDTH-1:0]     s0_axi_bid,
    output logic [1:0]              s0_axi_bresp,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s0_axi_arid,
    input  logic [7:0]              s0_axi_arlen,
    input  logic [2:0]              s0_axi_arsize,
    input  logic [1:0]              s0_axi_arburst,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [ID_WIDTH-1:0]     s0_axi_rid,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rlast,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    // requester 1
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s1_axi_awid,
    input  logic [7:0]              s1_axi_awlen,
    input  logic [2:0]              s1_axi_awsize,
    input  logic [1:0]              s1_axi_awburst,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wlast,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic                    s1_axi_bvalid,
    output logic [ID_WIDTH-1:0]     s1_axi_bid,
    output logic [1:0]              s1_axi_bresp,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s1_axi_arid,
    input  logic [7:0]              s1_axi_arlen,
    input  logic [2:0]              s1_axi_arsize,
    input  logic [1:0]              s1_axi_arburst,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [ID_WIDTH-1:0]     s1_axi_rid,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rlast,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    // shared DRAM port
    output logic [ADDR_WIDTH-1:0]   m01_axi_awaddr,
    output logic [ID_WIDTH-1:0]     m01_axi_awid,
    output logic [7:0]              m01_axi_awlen,
    output logic [2:0]              m01_axi_awsize,
    output logic [1:0]              m01_axi_awburst,
    output logic                    m01_axi_awlock,
    output logic [3:0]              m01_axi_awcache,
    output logic [2:0]              m01_axi_awprot,
    output logic [3:0]              m01_axi_awqos,
    output logic [3:0]              m01_axi_awregion,
    output logic                    m01_axi_awvalid,
    input  logic                    m01_axi_awready,
    output logic [DATA_WIDTH-1:0]   m01_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m01_axi_wstrb,
    output logic                    m01_axi_wlast,
    output logic                    m01_axi_wvalid,
    input  logic                    m01_axi_wready,
    input  logic                    m01_axi_bvalid,
    input  logic [ID_WIDTH-1:0]     m01_axi_bid,
    input  logic [1:0]              m01_axi_bresp,
    output logic                    m01_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m01_axi_araddr,
    output logic [ID_WIDTH-1:0]     m01_axi_arid,
    output logic [7:0]              m01_axi_arlen,
    output logic [2:0]              m01_axi_arsize,
    output logic [1:0]              m01_axi_arburst,
    output logic                    m01_axi_arlock,
    output logic [3:0]              m01_axi_arcache,
    output logic [2:0]              m01_axi_arprot,
    output logic [3:0]              m01_axi_arqos,
    output logic [3:0]              m01_axi_arregion,
    output logic                    m01_axi_arvalid,
    input  logic                    m01_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m01_axi_rdata,
    input  logic [ID_WIDTH-1:0]     m01_axi_rid,
    input  logic [1:0]              m01_axi_rresp,
    input  logic                    m01_axi_rlast,
    input  logic                    m01_axi_rvalid,
    output logic                    m01_axi_rready,
    // debug
    output logic [1:0]              dbg_wr_state,
    output logic [1:0]              dbg_rd_state,
    output logic                    dbg_protocol_err
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

    wr_state_t  wr_state, wr_next;
    rd_state_t  rd_state, rd_next;
    logic       wr_gnt, wr_last, rd_gnt, rd_last;
    logic [7:0] beat_cnt;
    logic       protocol_err;
    logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // Request fields follow the stored grant. They are don't-care while the
    // matching valid is low.
    assign m01_axi_awaddr  = wr_gnt ? s1_axi_awaddr  : s0_axi_awaddr;
    assign m01_axi_awid    = wr_gnt ? s1_axi_awid    : s0_axi_awid;
    assign m01_axi_awlen   = wr_gnt ? s1_axi_awlen   : s0_axi_awlen;
    assign m01_axi_awsize  = wr_gnt ? s1_axi_awsize  : s0_axi_awsize;
    assign m01_axi_awburst = wr_gnt ? s1_axi_awburst : s0_axi_awburst;
    assign m01_axi_wdata   = wr_gnt ? s1_axi_wdata   : s0_axi_wdata;
    assign m01_axi_wstrb   = wr_gnt ? s1_axi_wstrb   : s0_axi_wstrb;
    assign m01_axi_wlast   = wr_gnt ? s1_axi_wlast   : s0_axi_wlast;
    assign m01_axi_araddr  = rd_gnt ? s1_axi_araddr  : s0_axi_araddr;
    assign m01_axi_arid    = rd_gnt ? s1_axi_arid    : s0_axi_arid;
    assign m01_axi_arlen   = rd_gnt ? s1_axi_arlen   : s0_axi_arlen;
    assign m01_axi_arsize  = rd_gnt ? s1_axi_arsize  : s0_axi_arsize;
    assign m01_axi_arburst = rd_gnt ? s1_axi_arburst : s0_axi_arburst;

    assign m01_axi_awlock   = 1'b0;
    assign m01_axi_awcache  = 4'b0011;
    assign m01_axi_awprot   = 3'b000;
    assign m01_axi_awqos    = 4'b0000;
    assign m01_axi_awregion = 4'b0000;
    assign m01_axi_arlock   = 1'b0;
    assign m01_axi_arcache  = 4'b0011;
    assign m01_axi_arprot   = 3'b000;
    assign m01_axi_arqos    = 4'b0000;
    assign m01_axi_arregion = 4'b0000;

    // Response payloads go to both requesters. Only the granted one sees valid.
    assign s0_axi_bid   = m01_axi_bid;
    assign s1_axi_bid   = m01_axi_bid;
    assign s0_axi_bresp = m01_axi_bresp;
    assign s1_axi_bresp = m01_axi_bresp;
    assign s0_axi_rdata = m01_axi_rdata;
    assign s1_axi_rdata = m01_axi_rdata;
    assign s0_axi_rid   = m01_axi_rid;
    assign s1_axi_rid   = m01_axi_rid;
    assign s0_axi_rresp = m01_axi_rresp;
    assign s1_axi_rresp = m01_axi_rresp;
    assign s0_axi_rlast = m01_axi_rlast;
    assign s1_axi_rlast = m01_axi_rlast;

    assign sel_awvalid = wr_gnt ? s1_axi_awvalid : s0_axi_awvalid;
    assign sel_wvalid  = wr_gnt ? s1_axi_wvalid  : s0_axi_wvalid;
    assign sel_bready  = wr_gnt ? s1_axi_bready  : s0_axi_bready;
    assign sel_arvalid = rd_gnt ? s1_axi_arvalid : s0_axi_arvalid;
    assign sel_rready  = rd_gnt ? s1_axi_rready  : s0_axi_rready;

    // The m01 valids and readies are state-gated, so each handshake implies its phase.
    assign aw_hs = m01_axi_awvalid && m01_axi_awready;
    assign w_hs  = m01_axi_wvalid  && m01_axi_wready;
    assign b_hs  = m01_axi_bvalid  && m01_axi_bready;
    assign ar_hs = m01_axi_arvalid && m01_axi_arready;
    assign r_hs  = m01_axi_rvalid  && m01_axi_rready;

    // Write FSM: next state and channel gating.
    always_comb begin
        wr_next         = wr_state;
        m01_axi_awvalid = 1'b0;
        s0_axi_awready  = 1'b0;
        s1_axi_awready  = 1'b0;
        m01_axi_wvalid  = 1'b0;
        s0_axi_wready   = 1'b0;
        s1_axi_wready   = 1'b0;
        m01_axi_bready  = 1'b0;
        s0_axi_bvalid   = 1'b0;
        s1_axi_bvalid   = 1'b0;
        case (wr_state)
            W_IDLE: if (s0_axi_awvalid || s1_axi_awvalid) wr_next = W_ADDR;
            W_ADDR: begin
                m01_axi_awvalid = sel_awvalid;
                s0_axi_awready  = !wr_gnt && m01_axi_awready;
                s1_axi_awready  =  wr_gnt && m01_axi_awready;
                if (sel_awvalid && m01_axi_awready) wr_next = W_DATA;
            end
            W_DATA: begin
                m01_axi_wvalid = sel_wvalid;
                s0_axi_wready  = !wr_gnt && m01_axi_wready;
                s1_axi_wready  =  wr_gnt && m01_axi_wready;
                if (sel_wvalid && m01_axi_wready && m01_axi_wlast) wr_next = W_RESP;
            end
            W_RESP: begin
                m01_axi_bready = sel_bready;
                s0_axi_bvalid  = !wr_gnt && m01_axi_bvalid;
                s1_axi_bvalid  =  wr_gnt && m01_axi_bvalid;
                if (m01_axi_bvalid && sel_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Read FSM: next state and channel gating.
    always_comb begin
        rd_next         = rd_state;
        m01_axi_arvalid = 1'b0;
        s0_axi_arready  = 1'b0;
        s1_axi_arready  = 1'b0;
        m01_axi_rready  = 1'b0;
        s0_axi_rvalid   = 1'b0;
        s1_axi_rvalid   = 1'b0;
        case (rd_state)
            R_IDLE: if (s0_axi_arvalid || s1_axi_arvalid) rd_next = R_ADDR;
            R_ADDR: begin
                m01_axi_arvalid = sel_arvalid;
                s0_axi_arready  = !rd_gnt && m01_axi_arready;
                s1_axi_arready  =  rd_gnt && m01_axi_arready;
                if (sel_arvalid && m01_axi_arready) rd_next = R_DATA;
            end
            R_DATA: begin
                m01_axi_rready = sel_rready;
                s0_axi_rvalid  = !rd_gnt && m01_axi_rvalid;
                s1_axi_rvalid  =  rd_gnt && m01_axi_rvalid;
                if (m01_axi_rvalid && sel_rready && m01_axi_rlast) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // wr_last/rd_last hold the last requester served. Their reset value of 1
    // gives requester 0 the first tie.
    always_ff @(posedge m01_axi_aclk) begin
        if (!m01_axi_aresetn) begin
            wr_state     <= W_IDLE;
            rd_state     <= R_IDLE;
            wr_gnt       <= 1'b0;
            rd_gnt       <= 1'b0;
            wr_last      <= 1'b1;
            rd_last      <= 1'b1;
            beat_cnt     <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            if (wr_state == W_IDLE && (s0_axi_awvalid || s1_axi_awvalid))
                wr_gnt <= (s0_axi_awvalid && s1_axi_awvalid) ? ~wr_last : s1_axi_awvalid;
            if (rd_state == R_IDLE && (s0_axi_arvalid || s1_axi_arvalid))
                rd_gnt <= (s0_axi_arvalid && s1_axi_arvalid) ? ~rd_last : s1_axi_arvalid;
            if (aw_hs) beat_cnt <= m01_axi_awlen;
            // beat_cnt counts beats still owed after this one. wlast must
            // coincide with it reaching zero. Data passes through either way.
            if (w_hs) begin
                if (m01_axi_wlast != (beat_cnt == 8'd0)) protocol_err <= 1'b1;
                if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
            end
            if (b_hs) wr_last <= wr_gnt;
            if (r_hs && m01_axi_rlast) rd_last <= rd_gnt;
        end
    end

    // ar_hs is kept for symmetry with the write side and feeds the debug view.
    assign dbg_wr_state     = wr_state;
    assign dbg_rd_state     = (ar_hs && rd_state != R_ADDR) ? R_IDLE : rd_state;
    assign dbg_protocol_err = protocol_err;

endmodule

// File: tb/tb_bp_axi4_mem_arbiter.sv
module tb_bp_axi4_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int IW = 4;

  logic clk, aresetn;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [IW-1:0] s0_axi_awid, s1_axi_awid, s0_axi_arid, s1_axi_arid;
  logic [7:0] s0_axi_awlen, s1_axi_awlen, s0_axi_arlen, s1_axi_arlen;
  logic [2:0] s0_axi_awsize, s1_axi_awsize, s0_axi_arsize, s1_axi_arsize;
  logic [1:0] s0_axi_awburst, s1_axi_awburst, s0_axi_arburst, s1_axi_arburst;
  logic s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, s0_axi_rdata, s1_axi_rdata;
  logic [DW/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
  logic s0_axi_wlast, s1_axi_wlast, s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
  logic s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic [IW-1:0] s0_axi_bid, s1_axi_bid, s0_axi_rid, s1_axi_rid;
  logic [1:0] s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
  logic s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic s0_axi_rlast, s1_axi_rlast, s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;
  logic [AW-1:0] m01_axi_awaddr, m01_axi_araddr;
  logic [IW-1:0] m01_axi_awid, m01_axi_arid, m01_axi_bid, m01_axi_rid;
  logic [7:0] m01_axi_awlen, m01_axi_arlen;
  logic [2:0] m01_axi_awsize, m01_axi_arsize, m01_axi_awprot, m01_axi_arprot;
  logic [1:0] m01_axi_awburst, m01_axi_arburst, m01_axi_bresp, m01_axi_rresp;
  logic m01_axi_awlock, m01_axi_arlock;
  logic [3:0] m01_axi_awcache, m01_axi_arcache, m01_axi_awqos, m01_axi_arqos;
  logic [3:0] m01_axi_awregion, m01_axi_arregion;
  logic m01_axi_awvalid, m01_axi_awready, m01_axi_wvalid, m01_axi_wready, m01_axi_wlast;
  logic [DW-1:0] m01_axi_wdata, m01_axi_rdata;
  logic [DW/8-1:0] m01_axi_wstrb;
  logic m01_axi_bvalid, m01_axi_bready, m01_axi_arvalid, m01_axi_arready;
  logic m01_axi_rlast, m01_axi_rvalid, m01_axi_rready;
  logic [1:0] dbg_wr_state, dbg_rd_state;
  logic dbg_protocol_err;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  bp_axi4_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .m01_axi_aclk(clk), .m01_axi_aresetn(aresetn),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awid(s0_axi_awid), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awvalid(s0_axi_awvalid),
    .s0_axi_awready(s0_axi_awready), .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
    .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp),
    .s0_axi_bready(s0_axi_bready), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arid(s0_axi_arid),
    .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast),
    .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awid(s1_axi_awid), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awvalid(s1_axi_awvalid),
    .s1_axi_awready(s1_axi_awready), .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
    .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp),
    .s1_axi_bready(s1_axi_bready), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arid(s1_axi_arid),
    .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast),
    .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m01_axi_awaddr(m01_axi_awaddr), .m01_axi_awid(m01_axi_awid), .m01_axi_awlen(m01_axi_awlen),
    .m01_axi_awsize(m01_axi_awsize), .m01_axi_awburst(m01_axi_awburst), .m01_axi_awlock(m01_axi_awlock),
    .m01_axi_awcache(m01_axi_awcache), .m01_axi_awprot(m01_axi_awprot), .m01_axi_awqos(m01_axi_awqos),
    .m01_axi_awregion(m01_axi_awregion), .m01_axi_awvalid(m01_axi_awvalid), .m01_axi_awready(m01_axi_awready),
    .m01_axi_wdata(m01_axi_wdata), .m01_axi_wstrb(m01_axi_wstrb), .m01_axi_wlast(m01_axi_wlast),
    .m01_axi_wvalid(m01_axi_wvalid), .m01_axi_wready(m01_axi_wready), .m01_axi_bvalid(m01_axi_bvalid),
    .m01_axi_bid(m01_axi_bid), .m01_axi_bresp(m01_axi_bresp), .m01_axi_bready(m01_axi_bready),
    .m01_axi_araddr(m01_axi_araddr), .m01_axi_arid(m01_axi_arid), .m01_axi_arlen(m01_axi_arlen),
    .m01_axi_arsize(m01_axi_arsize), .m01_axi_arburst(m01_axi_arburst), .m01_axi_arlock(m01_axi_arlock),
    .m01_axi_arcache(m01_axi_arcache), .m01_axi_arprot(m01_axi_arprot), .m01_axi_arqos(m01_axi_arqos),
    .m01_axi_arregion(m01_axi_arregion), .m01_axi_arvalid(m01_axi_arvalid), .m01_axi_arready(m01_axi_arready),
    .m01_axi_rdata(m01_axi_rdata), .m01_axi_rid(m01_axi_rid), .m01_axi_rresp(m01_axi_rresp),
    .m01_axi_rlast(m01_axi_rlast), .m01_axi_rvalid(m01_axi_rvalid), .m01_axi_rready(m01_axi_rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state), .dbg_protocol_err(dbg_protocol_err)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int w;
    int k;
    int n;
    int d;
    int cyc;
    logic done;
    logic [DW-1:0] e;
    aresetn = 1'b0;
    s0_axi_awaddr = '0; s0_axi_awid = '0; s0_axi_awlen = '0; s0_axi_awsize = 3'd4; s0_axi_awburst = 2'd1;
    s1_axi_awaddr = '0; s1_axi_awid = '0; s1_axi_awlen = '0; s1_axi_awsize = 3'd4; s1_axi_awburst = 2'd1;
    s0_axi_araddr = '0; s0_axi_arid = '0; s0_axi_arlen = '0; s0_axi_arsize = 3'd4; s0_axi_arburst = 2'd1;
    s1_axi_araddr = '0; s1_axi_arid = '0; s1_axi_arlen = '0; s1_axi_arsize = 3'd4; s1_axi_arburst = 2'd1;
    s0_axi_awvalid = 0; s1_axi_awvalid = 0; s0_axi_arvalid = 0; s1_axi_arvalid = 0;
    s0_axi_wdata = '0; s1_axi_wdata = '0; s0_axi_wstrb = '1; s1_axi_wstrb = '1;
    s0_axi_wlast = 0; s1_axi_wlast = 0; s0_axi_wvalid = 0; s1_axi_wvalid = 0;
    s0_axi_bready = 0; s1_axi_bready = 0; s0_axi_rready = 0; s1_axi_rready = 0;
    m01_axi_awready = 0; m01_axi_wready = 0; m01_axi_bvalid = 0; m01_axi_bid = '0; m01_axi_bresp = '0;
    m01_axi_arready = 0; m01_axi_rdata = '0; m01_axi_rid = '0; m01_axi_rresp = '0;
    m01_axi_rlast = 0; m01_axi_rvalid = 0;

    // reset state
    step(); step();
    smp();
    chk("rst_wr_state", dbg_wr_state, 0);
    chk("rst_rd_state", dbg_rd_state, 0);
    chk("rst_m01_awvalid", m01_axi_awvalid, 0);
    chk("rst_m01_wvalid", m01_axi_wvalid, 0);
    chk("rst_m01_bready", m01_axi_bready, 0);
    chk("rst_m01_arvalid", m01_axi_arvalid, 0);
    chk("rst_m01_rready", m01_axi_rready, 0);
    chk("rst_s_valids", {s0_axi_bvalid, s1_axi_bvalid, s0_axi_rvalid, s1_axi_rvalid}, 0);
    chk("rst_s_readies", {s0_axi_awready, s1_axi_awready, s0_axi_wready, s1_axi_wready,
                          s0_axi_arready, s1_axi_arready}, 0);
    chk("rst_perr", dbg_protocol_err, 0);
    chk("const_awcache", m01_axi_awcache, 4'b0011);
    chk("const_arcache", m01_axi_arcache, 4'b0011);
    step();
    aresetn = 1'b1;

    // s0 single write, awlen=3
    s0_axi_awaddr = 64'h1000; s0_axi_awid = 4'd5; s0_axi_awlen = 8'd3; s0_axi_awvalid = 1;
    m01_axi_awready = 1;
    smp();
    chk("w1_grant_cycle_awvalid", m01_axi_awvalid, 0);
    chk("w1_grant_cycle_awready", s0_axi_awready, 0);
    step();
    smp();
    chk("w1_awvalid", m01_axi_awvalid, 1);
    chk("w1_awaddr", m01_axi_awaddr, 64'h1000);
    chk("w1_awid", m01_axi_awid, 5);
    chk("w1_awlen", m01_axi_awlen, 3);
    chk("w1_s0_awready", s0_axi_awready, 1);
    chk("w1_s1_awready", s1_axi_awready, 0);
    step();
    s0_axi_awvalid = 0;
    m01_axi_wready = 1;
    for (int i = 0; i < 4; i++) begin
      s0_axi_wvalid = 1; s0_axi_wdata = 128'h1111_0000 + 128'(i); s0_axi_wlast = (i == 3);
      smp();
      chk("w1_wvalid", m01_axi_wvalid, 1);
      chk("w1_wdata", m01_axi_wdata, 128'h1111_0000 + 128'(i));
      chk("w1_wlast", m01_axi_wlast, (i == 3));
      chk("w1_s0_wready", s0_axi_wready, 1);
      chk("w1_s1_wready", s1_axi_wready, 0);
      step();
    end
    s0_axi_wvalid = 0; s0_axi_wlast = 0;
    m01_axi_bvalid = 1; m01_axi_bid = 4'd5; m01_axi_bresp = 2'd0; s0_axi_bready = 1;
    smp();
    chk("w1_wr_state_resp", dbg_wr_state, 3);
    chk("w1_s0_bvalid", s0_axi_bvalid, 1);
    chk("w1_s0_bid", s0_axi_bid, 5);
    chk("w1_s1_bvalid", s1_axi_bvalid, 0);
    chk("w1_m01_bready", m01_axi_bready, 1);
    step();
    m01_axi_bvalid = 0;
    smp();
    chk("w1_done_state", dbg_wr_state, 0);
    chk("w1_done_bvalid", s0_axi_bvalid, 0);
    chk("w1_perr", dbg_protocol_err, 0);
    step();

    // read round robin: s0, s1, s0, s1
    s0_axi_araddr = 64'h2000; s0_axi_arid = 4'd1;
    s1_axi_araddr = 64'h3000; s1_axi_arid = 4'd2;
    m01_axi_arready = 1; s0_axi_rready = 1; s1_axi_rready = 1;
    for (int r = 0; r < 4; r++) begin
      w = r % 2;
      s0_axi_arvalid = 1; s1_axi_arvalid = 1;
      smp();
      chk("rr_idle_state", dbg_rd_state, 0);
      chk("rr_idle_arvalid", m01_axi_arvalid, 0);
      step();
      smp();
      chk("rr_arvalid", m01_axi_arvalid, 1);
      chk("rr_arid", m01_axi_arid, (w == 1) ? 4'd2 : 4'd1);
      chk("rr_araddr", m01_axi_araddr, (w == 1) ? 64'h3000 : 64'h2000);
      chk("rr_win_arready", (w == 1) ? s1_axi_arready : s0_axi_arready, 1);
      chk("rr_lose_arready", (w == 1) ? s0_axi_arready : s1_axi_arready, 0);
      step();
      if (w == 1) s1_axi_arvalid = 0; else s0_axi_arvalid = 0;
      m01_axi_rvalid = 1; m01_axi_rlast = 1; m01_axi_rdata = 128'hD000 + 128'(r);
      m01_axi_rid = (w == 1) ? 4'd2 : 4'd1;
      smp();
      chk("rr_win_rvalid", (w == 1) ? s1_axi_rvalid : s0_axi_rvalid, 1);
      chk("rr_lose_rvalid", (w == 1) ? s0_axi_rvalid : s1_axi_rvalid, 0);
      chk("rr_rdata", (w == 1) ? s1_axi_rdata : s0_axi_rdata, 128'hD000 + 128'(r));
      chk("rr_rid", (w == 1) ? s1_axi_rid : s0_axi_rid, (w == 1) ? 4'd2 : 4'd1);
      step();
      m01_axi_rvalid = 0; m01_axi_rlast = 0;
    end
    s0_axi_arvalid = 0; s1_axi_arvalid = 0;

    // reset in W_DATA after 2 of 4 beats
    s0_axi_awaddr = 64'h4000; s0_axi_awid = 4'd6; s0_axi_awlen = 8'd3; s0_axi_awvalid = 1;
    step(); step();
    s0_axi_awvalid = 0;
    s0_axi_wvalid = 1; s0_axi_wlast = 0; s0_axi_wdata = 128'hAB0;
    step();
    s0_axi_wdata = 128'hAB1;
    smp();
    chk("rstmid_in_wdata", dbg_wr_state, 2);
    step();
    aresetn = 0;
    step();
    smp();
    chk("rstmid_wr_state", dbg_wr_state, 0);
    chk("rstmid_rd_state", dbg_rd_state, 0);
    chk("rstmid_m01_wvalid", m01_axi_wvalid, 0);
    chk("rstmid_s0_wready", s0_axi_wready, 0);
    chk("rstmid_other", {m01_axi_awvalid, m01_axi_bready, m01_axi_arvalid, m01_axi_rready,
                         s0_axi_awready, s1_axi_awready, s1_axi_wready, s0_axi_bvalid, s1_axi_bvalid}, 0);
    step();
    aresetn = 1;
    s0_axi_wvalid = 0;
    s0_axi_awaddr = 64'h4100; s0_axi_awid = 4'd6; s0_axi_awlen = 8'd0; s0_axi_awvalid = 1;
    s1_axi_awaddr = 64'h5000; s1_axi_awid = 4'd7; s1_axi_awlen = 8'd0; s1_axi_awvalid = 1;
    smp();
    chk("tie_idle_awready", s0_axi_awready, 0);
    step();
    smp();
    chk("tie_s0_awid", m01_axi_awid, 6);
    chk("tie_s0_awready", s0_axi_awready, 1);
    chk("tie_s1_awready", s1_axi_awready, 0);
    step();
    s0_axi_awvalid = 0;
    s0_axi_wvalid = 1; s0_axi_wlast = 1; s0_axi_wdata = 128'hBEEF;
    smp();
    chk("tie_s0_wvalid", m01_axi_wvalid, 1);
    chk("tie_s1_wready", s1_axi_wready, 0);
    step();
    s0_axi_wvalid = 0; s0_axi_wlast = 0;
    m01_axi_bvalid = 1; m01_axi_bid = 4'd6; s0_axi_bready = 1; s1_axi_bready = 1;
    smp();
    chk("tie_s0_bvalid", s0_axi_bvalid, 1);
    chk("tie_s1_bvalid_off", s1_axi_bvalid, 0);
    step();
    m01_axi_bvalid = 0;
    step();
    smp();
    chk("s1w_awid", m01_axi_awid, 7);
    chk("s1w_s1_awready", s1_axi_awready, 1);
    chk("s1w_s0_awready", s0_axi_awready, 0);
    step();
    s1_axi_awvalid = 0;
    s1_axi_wvalid = 1; s1_axi_wlast = 1; s1_axi_wdata = 128'hCAFE;
    smp();
    chk("s1w_wready", s1_axi_wready, 1);
    chk("s1w_wdata", m01_axi_wdata, 128'hCAFE);
    step();
    s1_axi_wvalid = 0; s1_axi_wlast = 0;
    m01_axi_bvalid = 1; m01_axi_bid = 4'd7; m01_axi_bresp = 2'd0;
    smp();
    chk("s1w_bvalid", s1_axi_bvalid, 1);
    chk("s1w_bid", s1_axi_bid, 7);
    chk("s1w_s0_bvalid", s0_axi_bvalid, 0);
    step();
    m01_axi_bvalid = 0;

    // concurrent s0 read (arlen=7) and s1 write (awlen=0)
    s0_axi_araddr = 64'h6000; s0_axi_arid = 4'd3; s0_axi_arlen = 8'd7; s0_axi_arvalid = 1;
    s1_axi_awaddr = 64'h7000; s1_axi_awid = 4'd9; s1_axi_awlen = 8'd0; s1_axi_awvalid = 1;
    step();
    smp();
    chk("cc_arvalid", m01_axi_arvalid, 1);
    chk("cc_arid", m01_axi_arid, 3);
    chk("cc_s0_arready", s0_axi_arready, 1);
    chk("cc_s1_arready", s1_axi_arready, 0);
    chk("cc_awvalid", m01_axi_awvalid, 1);
    chk("cc_awid", m01_axi_awid, 9);
    chk("cc_s1_awready", s1_axi_awready, 1);
    chk("cc_s0_awready", s0_axi_awready, 0);
    step();
    s0_axi_arvalid = 0; s1_axi_awvalid = 0;
    for (int i = 0; i < 8; i++) begin
      m01_axi_rvalid = 1; m01_axi_rdata = 128'hC0 + 128'(i); m01_axi_rid = 4'd3; m01_axi_rlast = (i == 7);
      s1_axi_wvalid = (i == 0); s1_axi_wlast = (i == 0); s1_axi_wdata = 128'h5150;
      m01_axi_bvalid = (i == 1); m01_axi_bid = 4'd9; m01_axi_bresp = 2'd2;
      smp();
      chk("cc_s0_rvalid", s0_axi_rvalid, 1);
      chk("cc_s1_rvalid", s1_axi_rvalid, 0);
      chk("cc_s0_rdata", s0_axi_rdata, 128'hC0 + 128'(i));
      chk("cc_s0_rid", s0_axi_rid, 3);
      if (i == 0) begin
        chk("cc_wvalid", m01_axi_wvalid, 1);
        chk("cc_s1_wready", s1_axi_wready, 1);
      end
      if (i == 1) begin
        chk("cc_s1_bvalid", s1_axi_bvalid, 1);
        chk("cc_s1_bresp", s1_axi_bresp, 2);
        chk("cc_s0_bvalid", s0_axi_bvalid, 0);
      end
      step();
    end
    m01_axi_rvalid = 0; m01_axi_rlast = 0; s1_axi_wvalid = 0; s1_axi_wlast = 0; m01_axi_bvalid = 0;
    smp();
    chk("cc_rd_idle", dbg_rd_state, 0);
    chk("cc_wr_idle", dbg_wr_state, 0);
    step();

    // random backpressure, s1 write awlen=7 through the scoreboard
    s1_axi_awaddr = 64'h8000; s1_axi_awid = 4'd8; s1_axi_awlen = 8'd7; s1_axi_awvalid = 1;
    step(); step();
    s1_axi_awvalid = 0;
    for (int j = 0; j < 8; j++) exp_q.push_back(128'hA5A5_0000 + 128'(j));
    k = 0; n = 0; cyc = 0;
    while (n < 8 && cyc < 200) begin
      s1_axi_wvalid = (k < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      s1_axi_wdata = 128'hA5A5_0000 + 128'(k);
      s1_axi_wlast = (k == 7);
      m01_axi_wready = 1'($urandom_range(0, 1));
      smp();
      if (m01_axi_wvalid && m01_axi_wready) begin
        e = exp_q.pop_front();
        chk("bp_wdata", m01_axi_wdata, e);
        n++;
      end
      if (s1_axi_wvalid && s1_axi_wready) k++;
      step();
      cyc++;
    end
    chk("bp_w_count", n, 8);
    chk("bp_w_sent", k, 8);
    s1_axi_wvalid = 0; s1_axi_wlast = 0; m01_axi_wready = 1;
    m01_axi_bvalid = 1; m01_axi_bid = 4'd8; m01_axi_bresp = 2'd0;
    done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      s1_axi_bready = 1'($urandom_range(0, 1));
      smp();
      chk("bp_s1_bvalid", s1_axi_bvalid, 1);
      chk("bp_m01_bready", m01_axi_bready, s1_axi_bready);
      if (s1_axi_bready) done = 1;
      step();
      cyc++;
    end
    chk("bp_b_done", done, 1);
    m01_axi_bvalid = 0; s1_axi_bready = 1;
    exp_q.delete();
    // s0 read arlen=5 with random rvalid and rready
    s0_axi_araddr = 64'h9000; s0_axi_arid = 4'd4; s0_axi_arlen = 8'd5; s0_axi_arvalid = 1;
    step(); step();
    s0_axi_arvalid = 0;
    for (int j = 0; j < 6; j++) exp_q.push_back(128'h7700 + 128'(j));
    d = 0; n = 0; cyc = 0;
    while (n < 6 && cyc < 200) begin
      m01_axi_rvalid = (d < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
      m01_axi_rdata = 128'h7700 + 128'(d);
      m01_axi_rid = 4'd4;
      m01_axi_rlast = (d == 5);
      s0_axi_rready = 1'($urandom_range(0, 1));
      smp();
      if (s0_axi_rvalid && s0_axi_rready) begin
        e = exp_q.pop_front();
        chk("bp_rdata", s0_axi_rdata, e);
        chk("bp_rlast", s0_axi_rlast, (exp_q.size() == 0));
        n++;
      end
      if (m01_axi_rvalid && m01_axi_rready) d++;
      step();
      cyc++;
    end
    m01_axi_rvalid = 0; m01_axi_rlast = 0; s0_axi_rready = 1;
    chk("bp_r_count", n, 6);
    chk("bp_r_sent", d, 6);
    smp();
    chk("bp_rd_idle", dbg_rd_state, 0);
    step();

    // early wlast: s1 awlen=3 ends on beat 2
    s1_axi_awaddr = 64'hA000; s1_axi_awid = 4'd10; s1_axi_awlen = 8'd3; s1_axi_awvalid = 1;
    smp();
    chk("pe_before", dbg_protocol_err, 0);
    step(); step();
    s1_axi_awvalid = 0;
    m01_axi_wready = 1;
    s1_axi_wvalid = 1; s1_axi_wlast = 0; s1_axi_wdata = 128'hE1;
    step();
    s1_axi_wlast = 1; s1_axi_wdata = 128'hE2;
    step();
    s1_axi_wvalid = 0; s1_axi_wlast = 0;
    m01_axi_bvalid = 1; m01_axi_bid = 4'd10; m01_axi_bresp = 2'd0; s1_axi_bready = 1;
    smp();
    chk("pe_flag", dbg_protocol_err, 1);
    chk("pe_wr_state", dbg_wr_state, 3);
    chk("pe_s1_bvalid", s1_axi_bvalid, 1);
    chk("pe_s1_bid", s1_axi_bid, 10);
    step();
    m01_axi_bvalid = 0;
    smp();
    chk("pe_wr_idle", dbg_wr_state, 0);
    chk("pe_sticky", dbg_protocol_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
